// File: rtl/dcache_wb_buffer_if.sv
// AXI3 write-address/data/response channel bundle between the write-back buffer and the fabric.
interface dcache_wb_buffer_if;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/dcache_wb_buffer.sv
// Dcache eviction write-back buffer: queues whole lines and drains each as one 4-beat AXI INCR burst.
module dcache_wb_buffer #(
    parameter int unsigned DEPTH = 2,
    parameter logic [3:0]  WR_ID = 4'd1
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               wr_req,
    input  logic [31:0]        wr_addr,
    input  logic [127:0]       wr_data,
    output logic               wr_rdy,
    input  logic [31:0]        chk_addr,
    output logic               chk_hit,
    output logic               empty,
    dcache_wb_buffer_if.master axi
);
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned TAG_W  = 28;
    localparam int unsigned LINE_W = 128;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AW   = 2'd1,
        S_W    = 2'd2,
        S_B    = 2'd3
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [TAG_W-1:0]   tag_q  [DEPTH];
    logic [LINE_W-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [1:0]         beat_q;
    logic               push;
    logic               pop;
    logic               beat_acc;
    logic [DEPTH-1:0]   set_mask;
    logic [DEPTH-1:0]   clr_mask;

    assign wr_rdy   = (count_q != CNT_W'(DEPTH));
    assign push     = wr_req & wr_rdy;
    assign pop      = (state_q == S_B) & axi.bvalid;
    assign beat_acc = (state_q == S_W) & axi.wready;
    assign empty    = (count_q == '0) & (state_q == S_IDLE);
    assign set_mask = DEPTH'(push) << wr_ptr_q;
    assign clr_mask = DEPTH'(pop) << rd_ptr_q;

    // Line storage needs no reset: an entry is only read while its valid bit is set.
    always_ff @(posedge aclk) begin
        if (push) begin
            tag_q[wr_ptr_q]  <= wr_addr[31:4];
            data_q[wr_ptr_q] <= wr_data;
        end
    end

    // FIFO bookkeeping; push and pop never target the same slot because pop needs a held head.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            valid_q <= (valid_q | set_mask) & ~clr_mask;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Beat index within the current burst; wraps to 0 after the last beat.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            beat_q <= '0;
        end else if (state_q == S_IDLE) begin
            beat_q <= '0;
        end else if (beat_acc) begin
            beat_q <= beat_q + 2'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // One burst outstanding: address, then data, then response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (count_q != '0) state_d = S_AW;
            S_AW:    if (axi.awready) state_d = S_W;
            S_W:     if (axi.wready && (beat_q == 2'd3)) state_d = S_B;
            S_B:     if (axi.bvalid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Channel outputs come only from state, beat counter and the head entry.
    always_comb begin
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        case (state_q)
            S_AW:    axi.awvalid = 1'b1;
            S_W:     axi.wvalid  = 1'b1;
            S_B:     axi.bready  = 1'b1;
            default: ;
        endcase
        axi.awaddr = {tag_q[rd_ptr_q], 4'h0};
        axi.wdata  = data_q[rd_ptr_q][{beat_q, 5'b0} +: WORD_W];
        axi.wlast  = (state_q == S_W) && (beat_q == 2'd3);
    end

    assign axi.awid    = WR_ID;
    assign axi.awlen   = 4'd3;
    assign axi.awsize  = 3'd2;
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'h0;
    assign axi.awprot  = 3'h0;
    assign axi.wid     = WR_ID;
    assign axi.wstrb   = 4'hf;

    // Refill hazard check against every held line, including the one being drained.
    always_comb begin
        chk_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == chk_addr[31:4])) begin
                chk_hit = 1'b1;
            end
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{axi.bid, axi.bresp, wr_addr[3:0], chk_addr[3:0]};

endmodule
